result_streamer: RTL
====================

RESULT_STREAMER -- requirements
Module: result_streamer

Interface
REQ-001 SHALL have parameter: N, 16, matrix dimension; legal 2..16; result count N*N; read address width 8 bits.
REQ-002 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  one-cycle pulse from the compute unit's done; begins a drain.
REQ-005 SHALL have port: busy  output  1  high from the cycle after accepted start until the done pulse.
REQ-006 SHALL have port: rd_en  output  1  result-BRAM read strobe.
REQ-007 SHALL have port: rd_addr  output  8  result-BRAM address, row-major, row*N+col.
REQ-008 SHALL have port: rd_q  input  32  result-BRAM read data, valid exactly 1 cycle after rd_en.
REQ-009 SHALL have port: out_valid  output  1  stream word valid.
REQ-010 SHALL have port: out_ready  input  1  downstream accepts word when high with out_valid.
REQ-011 SHALL have port: out_data  output  32  result word.
REQ-012 SHALL have port: out_last  output  1  high with word N*N-1 only.
REQ-013 SHALL have port: done  output  1  one-cycle pulse after the last word handshake.

Function
REQ-014 SHALL implement FSM IDLE -> RUN -> FIN -> IDLE; start is sampled only in IDLE; start in RUN/FIN is ignored.
REQ-015 SHALL, in RUN, issue reads for addresses 0..N*N-1 in ascending order, one per cycle max, rd_en never asserted for address >= N*N.
REQ-016 SHALL hold returned words in a 2-entry FIFO; a read issues only when (FIFO occupancy + reads in flight) < 2.
REQ-017 SHALL present FIFO head on out_data/out_valid; handshake = out_valid && out_ready pops one entry.
REQ-018 SHALL keep out_data and out_last stable while out_valid && !out_ready.
REQ-019 SHALL allow simultaneous push and pop when FIFO is full or empty-with-inflight without loss or duplication.
REQ-020 SHALL, with out_ready held high, give start in cycle 0, rd_en/addr 0 in cycle 1, first out_valid in cycle 2, word k in cycle 2+k, last in cycle N*N+1.
REQ-021 SHALL enter FIN on the handshake of the out_last word; FIN asserts done for exactly one cycle and returns to IDLE.
REQ-022 SHALL drive rd_addr to 0 and rd_en low whenever not issuing a read.
REQ-023 SHALL sustain one word per cycle throughput when out_ready is continuously high.
REQ-024 SHALL accept a new start in the cycle following the done pulse.

Reset
REQ-025 SHALL, on rst low at any time, asynchronously force state IDLE, FIFO empty, in-flight cleared, address counter 0.
REQ-026 SHALL reset outputs: busy 0, rd_en 0, rd_addr 0, out_valid 0, out_data 0, out_last 0, done 0; plus sum_valid 0, sum_data 0 when configured.
REQ-027 SHALL discard any rd_q returned in the first cycle after reset release.

Configuration
REQ-028 SHALL, when RESULT_SUM_EN is defined, add outputs sum_data (32) and sum_valid (1): sum_data = modulo-2^32 sum of all N*N words accepted by handshake, sum_valid high coincident with done for one cycle, sum cleared at accepted start.
REQ-029 SHALL, when RESULT_SUM_EN is undefined, omit sum_data/sum_valid and the accumulator; all other behaviour identical.

Verification
REQ-030 SHALL cover: BRAM preloaded word[i]=i*3, out_ready always 1, start pulse -> 256 words 0,3,...,765 in cycles 2..257, out_last only on 765, done in cycle 258.
REQ-031 SHALL cover: out_ready toggling 1,0,0,1 repeating -> every word exactly once in order, data stable during stalls, never more than 2 reads outstanding+buffered.
REQ-032 SHALL cover: out_ready low for 20 cycles after start -> exactly 2 rd_en pulses (addr 0,1), then resumes at addr 2 when ready rises.
REQ-033 SHALL cover: second start pulse at word 100 -> ignored; stream completes 256 words, single done.
REQ-034 SHALL cover: rst low at word 50 for 1 cycle -> all outputs 0 immediately, no rd_en until next start, new start restarts at addr 0.
REQ-035 SHALL cover: RESULT_SUM_EN defined, word[i]=0xFFFFFFF0+i, N=16 -> sum_data = 0xFFFFF000+32640 mod 2^32 = 0x00006F80 with sum_valid on done.

Source files
------------

// File: rtl/result_streamer_if.sv
// ============================================================================
//  Module      : result_streamer_if
//  Description : Handshake bundle between the result streamer, the result
//                BRAM read port, the compute unit and the downstream sink.
//                Optional sum outputs are present when RESULT_SUM_EN is set.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface result_streamer_if;
  logic        start;
  logic        busy;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [31:0] rd_q;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        done;
`ifdef RESULT_SUM_EN
  logic [31:0] sum_data;
  logic        sum_valid;

  // Streamer side: drives the BRAM read port and the output stream
  modport master (
    input  start, rd_q, out_ready,
    output busy, rd_en, rd_addr, out_valid, out_data, out_last, done,
    output sum_data, sum_valid
  );

  // Environment side: compute unit, BRAM and downstream sink
  modport slave (
    output start, rd_q, out_ready,
    input  busy, rd_en, rd_addr, out_valid, out_data, out_last, done,
    input  sum_data, sum_valid
  );
`else
  // Streamer side: drives the BRAM read port and the output stream
  modport master (
    input  start, rd_q, out_ready,
    output busy, rd_en, rd_addr, out_valid, out_data, out_last, done
  );

  // Environment side: compute unit, BRAM and downstream sink
  modport slave (
    output start, rd_q, out_ready,
    input  busy, rd_en, rd_addr, out_valid, out_data, out_last, done
  );
`endif
endinterface

`default_nettype wire

// File: rtl/result_streamer.sv
// ============================================================================
//  Module      : result_streamer
//  Description : Drains an N*N result BRAM in row-major order into a
//                valid/ready stream. Reads are paced by a 2-entry skid FIFO
//                so that at most two words are ever buffered or in flight.
//                The FIFO head is bypassed from rd_q when the FIFO is empty,
//                which gives one word per cycle with a 2-cycle start latency.
//                Optional macro RESULT_SUM_EN adds a running modulo-2^32 sum
//                of accepted words (sum_data/sum_valid).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module result_streamer #(
  parameter int N = 16
) (
  input  wire logic          clk,
  input  wire logic          rst,   // asynchronous, active-low
  result_streamer_if.master  bus
);

  localparam logic [8:0] c_TOTAL = 9'(N * N);
  localparam logic [8:0] c_LAST  = 9'(N * N - 1);

  localparam logic [1:0] c_S_IDLE = 2'd0;
  localparam logic [1:0] c_S_RUN  = 2'd1;
  localparam logic [1:0] c_S_FIN  = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;

  logic [8:0]  r_addr_cnt;    // next BRAM address to read
  logic [8:0]  r_out_cnt;     // index of the word currently at the stream head
  logic        r_inflight;    // a read was issued last cycle; rd_q is valid now
  logic [31:0] r_fifo [2];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;

  logic        w_accept;
  logic        w_run;
  logic        w_issue;
  logic        w_valid;
  logic [31:0] w_head;
  logic        w_last;
  logic        w_pop;
  logic        w_fifo_pop;
  logic        w_push;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: start only matters in IDLE; last-word handshake ends RUN
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_S_IDLE: if (bus.start) w_next_state = c_S_RUN;
      c_S_RUN:  if (w_pop && w_last) w_next_state = c_S_FIN;
      c_S_FIN:  w_next_state = c_S_IDLE;
      default:  w_next_state = c_S_IDLE;
    endcase
  end

  // State-decoded outputs and read pacing
  always_comb begin
    w_accept = (r_state == c_S_IDLE) && bus.start;
    w_run    = (r_state == c_S_RUN);
    bus.busy = (r_state == c_S_RUN) || (r_state == c_S_FIN);
    bus.done = (r_state == c_S_FIN);
    // Buffered plus in-flight words may never exceed the FIFO depth of two
    w_issue  = w_run && (r_addr_cnt < c_TOTAL) &&
               (({1'b0, r_count} + {2'b00, r_inflight}) < 3'd2);
  end

  // Stream head: FIFO entries are older than the in-flight word, so the
  // in-flight word is only visible when the FIFO is empty
  always_comb begin
    w_valid    = (r_count != 2'd0) || r_inflight;
    w_head     = (r_count != 2'd0) ? r_fifo[r_rd_ptr] : bus.rd_q;
    w_last     = w_valid && (r_out_cnt == c_LAST);
    w_pop      = w_valid && bus.out_ready;
    w_fifo_pop = w_pop && (r_count != 2'd0);
    // An in-flight word consumed straight from rd_q bypasses the FIFO
    w_push     = r_inflight && !(w_pop && (r_count == 2'd0));

    bus.out_valid = w_valid;
    bus.out_data  = w_valid ? w_head : 32'd0;
    bus.out_last  = w_last;
    bus.rd_en     = w_issue;
    bus.rd_addr   = w_issue ? r_addr_cnt[7:0] : 8'd0;
  end

  // Address/word counters, in-flight tracking and the 2-entry FIFO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr_cnt <= 9'd0;
      r_out_cnt  <= 9'd0;
      r_inflight <= 1'b0;
      r_fifo[0]  <= 32'd0;
      r_fifo[1]  <= 32'd0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
    end else begin
      r_inflight <= w_issue;
      if (w_accept) begin
        r_addr_cnt <= 9'd0;
        r_out_cnt  <= 9'd0;
      end else begin
        if (w_issue) r_addr_cnt <= r_addr_cnt + 9'd1;
        if (w_pop)   r_out_cnt  <= r_out_cnt + 9'd1;
      end
      if (w_push) begin
        r_fifo[r_wr_ptr] <= bus.rd_q;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_fifo_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_fifo_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef RESULT_SUM_EN
  logic [31:0] r_sum;

  // Running sum of accepted words, cleared when a new drain is accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sum <= 32'd0;
    end else if (w_accept) begin
      r_sum <= 32'd0;
    end else if (w_pop) begin
      r_sum <= r_sum + w_head;
    end
  end

  // Sum is reported alongside the done pulse
  always_comb begin
    bus.sum_data  = r_sum;
    bus.sum_valid = (r_state == c_S_FIN);
  end
`endif

endmodule

`default_nettype wire
